// File: rtl/k423_dmem_resp_pkg.sv
// Shared widths, byte-enable encodings and FSM state type for the data-memory responder.
package k423_dmem_resp_pkg;

  localparam int unsigned CORE_XLEN    = 32;
  localparam int unsigned CORE_ADDR_W  = 32;
  localparam int unsigned CORE_FETCH_W = 32;
  localparam int unsigned CORE_WEN_W   = CORE_XLEN / 8;
  localparam int unsigned DMEM_LAT_W   = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [CORE_WEN_W-1:0] DMEM_WEN_READ = 4'b0000;
  localparam logic [CORE_WEN_W-1:0] DMEM_WEN_BYTE = 4'b0001;
  localparam logic [CORE_WEN_W-1:0] DMEM_WEN_HALF = 4'b0011;
  localparam logic [CORE_WEN_W-1:0] DMEM_WEN_WORD = 4'b1111;

endpackage

// File: rtl/k423_dmem_lane_align.sv
// Byte-lane steering for LSB-justified store data / enables and right-justified load data.
module k423_dmem_lane_align
  import k423_dmem_resp_pkg::*;
(
  input  logic [CORE_WEN_W-1:0]   wen_i,
  input  logic [1:0]              off_i,
  input  logic [CORE_FETCH_W-1:0] wdata_i,
  input  logic [CORE_XLEN-1:0]    rword_i,
  output logic [CORE_WEN_W-1:0]   wen_o,
  output logic [CORE_XLEN-1:0]    wdata_o,
  output logic [CORE_XLEN-1:0]    rdata_o,
  output logic                    align_err_o
);

  always_comb begin
    wen_o   = wen_i << off_i;
    wdata_o = CORE_XLEN'(wdata_i) << {off_i, 3'b000};
    rdata_o = rword_i >> {off_i, 3'b000};
    case (wen_i)
      DMEM_WEN_READ,
      DMEM_WEN_BYTE: align_err_o = 1'b0;
      DMEM_WEN_HALF: align_err_o = off_i[0];
      DMEM_WEN_WORD: align_err_o = (off_i != 2'b00);
      default:       align_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/k423_dmem_resp.sv
// Data-memory responder: accepts one LSU request, waits LATENCY cycles, returns read data or write ack.
module k423_dmem_resp
  import k423_dmem_resp_pkg::*;
#(
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       LATENCY   = 1,
  parameter logic [31:0]       BASE_ADDR = 32'h8000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    mem_req_vld_i,
  input  logic [CORE_WEN_W-1:0]   mem_req_wen_i,
  input  logic [CORE_ADDR_W-1:0]  mem_req_addr_i,
  input  logic [CORE_FETCH_W-1:0] mem_req_wdata_i,
  output logic                    mem_req_rdy_o,
  output logic                    mem_rsp_vld_o,
  output logic [CORE_XLEN-1:0]    mem_rsp_rdata_o,
  output logic                    mem_rsp_err_o,
  input  logic                    mem_rsp_rdy_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  dmem_state_e               state_q, state_d;
  logic [DMEM_LAT_W-1:0]     cnt_q, cnt_d;
  logic [CORE_WEN_W-1:0]     wen_q, wen_d;
  logic [CORE_ADDR_W-1:0]    addr_q, addr_d;
  logic [CORE_FETCH_W-1:0]   wdata_q, wdata_d;
  logic [CORE_XLEN-1:0]      rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [CORE_XLEN-1:0]      mem_q [DEPTH];

  logic [CORE_WEN_W-1:0]     cur_wen;
  logic [CORE_ADDR_W-1:0]    cur_addr;
  logic [CORE_FETCH_W-1:0]   cur_wdata;
  logic [CORE_ADDR_W-1:0]    offset;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic [CORE_XLEN-1:0]      rword;
  logic [CORE_WEN_W-1:0]     wen_sh;
  logic [CORE_XLEN-1:0]      wdata_sh;
  logic [CORE_XLEN-1:0]      rdata_sh;
  logic                      align_err;
  logic                      acc_err;
  logic                      enter_resp;
  logic                      req_rdy;
  logic                      commit;

  // With LATENCY==1 the array access happens on the acceptance edge, so the live request is used.
  always_comb begin
    if (state_q == DMEM_IDLE) begin
      cur_wen   = mem_req_wen_i;
      cur_addr  = mem_req_addr_i;
      cur_wdata = mem_req_wdata_i;
    end else begin
      cur_wen   = wen_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    offset   = cur_addr - BASE_ADDR;
    in_range = (cur_addr >= BASE_ADDR) && ({2'b00, offset[CORE_ADDR_W-1:2]} < 32'(DEPTH));
    idx      = offset[IDX_W+1:2];
    rword    = mem_q[idx];
    acc_err  = align_err || !in_range;
  end

  k423_dmem_lane_align u_lane_align (
    .wen_i       (cur_wen),
    .off_i       (cur_addr[1:0]),
    .wdata_i     (cur_wdata),
    .rword_i     (rword),
    .wen_o       (wen_sh),
    .wdata_o     (wdata_sh),
    .rdata_o     (rdata_sh),
    .align_err_o (align_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    req_rdy    = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        req_rdy = 1'b1;
        if (mem_req_vld_i) begin
          wen_d   = mem_req_wen_i;
          addr_d  = mem_req_addr_i;
          wdata_d = mem_req_wdata_i;
          if (LATENCY == 1) begin
            state_d    = DMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = DMEM_LAT_W'(LATENCY - 1);
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DMEM_LAT_W'(1)) begin
          state_d    = DMEM_RESP;
          enter_resp = 1'b1;
        end
      end
      DMEM_RESP: begin
        if (mem_rsp_rdy_i) begin
          state_d = DMEM_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || (cur_wen != DMEM_WEN_READ)) ? '0 : rdata_sh;
    end
  end

  // Gated by reset so a write landing on a reset edge is dropped.
  assign commit = enter_resp && !acc_err && rst_n_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int unsigned b = 0; b < CORE_WEN_W; b++) begin
        if (wen_sh[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign mem_req_rdy_o   = req_rdy && rst_n_i;
  assign mem_rsp_vld_o   = (state_q == DMEM_RESP);
  assign mem_rsp_rdata_o = rdata_q;
  assign mem_rsp_err_o   = err_q;

endmodule

// File: tb/tb_k423_dmem_resp.sv
// Directed bench for k423_dmem_resp: three instances with LATENCY 3, 4 and 1.
module tb_k423_dmem_resp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [3];
  logic        vld     [3];
  logic [3:0]  wen     [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic        rsp_rdy [3];
  logic        rdy     [3];
  logic        rvld    [3];
  logic [31:0] rdata   [3];
  logic        err     [3];

  int n_asrt = 0;
  int n_fail = 0;

  k423_dmem_resp #(.DEPTH(256), .LATENCY(3), .BASE_ADDR(32'h8000_0000)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .mem_req_vld_i(vld[0]), .mem_req_wen_i(wen[0]),
    .mem_req_addr_i(addr[0]), .mem_req_wdata_i(wdata[0]), .mem_req_rdy_o(rdy[0]),
    .mem_rsp_vld_o(rvld[0]), .mem_rsp_rdata_o(rdata[0]), .mem_rsp_err_o(err[0]),
    .mem_rsp_rdy_i(rsp_rdy[0])
  );

  k423_dmem_resp #(.DEPTH(256), .LATENCY(4), .BASE_ADDR(32'h8000_0000)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .mem_req_vld_i(vld[1]), .mem_req_wen_i(wen[1]),
    .mem_req_addr_i(addr[1]), .mem_req_wdata_i(wdata[1]), .mem_req_rdy_o(rdy[1]),
    .mem_rsp_vld_o(rvld[1]), .mem_rsp_rdata_o(rdata[1]), .mem_rsp_err_o(err[1]),
    .mem_rsp_rdy_i(rsp_rdy[1])
  );

  k423_dmem_resp #(.DEPTH(256), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .mem_req_vld_i(vld[2]), .mem_req_wen_i(wen[2]),
    .mem_req_addr_i(addr[2]), .mem_req_wdata_i(wdata[2]), .mem_req_rdy_o(rdy[2]),
    .mem_rsp_vld_o(rvld[2]), .mem_rsp_rdata_o(rdata[2]), .mem_rsp_err_o(err[2]),
    .mem_rsp_rdy_i(rsp_rdy[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request/response pair; latency counted as edges from acceptance to the first edge seeing rsp_vld.
  task automatic txn(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input string tag);
    int k;
    k = 0;
    vld[d]   = 1'b1;
    wen[d]   = w;
    addr[d]  = a;
    wdata[d] = wd;
    while (!rdy[d] && k < 50) begin
      step();
      k++;
    end
    step();
    vld[d] = 1'b0;
    k = 0;
    while (!rvld[d] && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_lat"}, 32'(k + 1), 32'(exp_lat));
    chk({tag, "_err"}, {31'b0, err[d]}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rdata[d], exp_rd);
    step();
  endtask

  initial begin
    int k;
    for (int d = 0; d < 3; d++) begin
      rst_n[d]   = 1'b0;
      vld[d]     = 1'b0;
      wen[d]     = 4'b0000;
      addr[d]    = '0;
      wdata[d]   = '0;
      rsp_rdy[d] = 1'b1;
    end
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdy", {31'b0, rdy[d]}, 32'd0);
      chk("rst_vld", {31'b0, rvld[d]}, 32'd0);
    end
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    step();
    chk("idle_rdy",   {31'b0, rdy[0]},  32'd1);
    chk("idle_vld",   {31'b0, rvld[0]}, 32'd0);
    chk("idle_rdata", rdata[0],          32'd0);
    chk("idle_err",   {31'b0, err[0]},  32'd0);

    // Word write/read, LATENCY=3
    txn(0, 4'b1111, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, "w_word");
    txn(0, 4'b0000, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, "r_word");

    // Lane steering
    txn(0, 4'b1111, 32'h8000_0000, 32'h0000_0000, 32'h0, 1'b0, 3, "w_zero");
    txn(0, 4'b0001, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1'b0, 3, "w_byte3");
    txn(0, 4'b0011, 32'h8000_0000, 32'h0000_1234, 32'h0, 1'b0, 3, "w_half0");
    txn(0, 4'b0000, 32'h8000_0000, 32'h0, 32'hA500_1234, 1'b0, 3, "r_w0");
    txn(0, 4'b0000, 32'h8000_0003, 32'h0, 32'h0000_00A5, 1'b0, 3, "r_off3");
    txn(0, 4'b0000, 32'h8000_0002, 32'h0, 32'h0000_A500, 1'b0, 3, "r_off2");

    // Misaligned, illegal enables, out of range
    txn(0, 4'b0011, 32'h8000_0001, 32'h0000_FFFF, 32'h0, 1'b1, 3, "e_half1");
    txn(0, 4'b1111, 32'h8000_0002, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, "e_word2");
    txn(0, 4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, "e_wen");
    txn(0, 4'b0000, 32'h8000_0000, 32'h0, 32'hA500_1234, 1'b0, 3, "r_w0_kept");
    txn(0, 4'b0000, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 3, "e_below");
    txn(0, 4'b0000, 32'h8000_0400, 32'h0, 32'h0, 1'b1, 3, "e_above");
    txn(0, 4'b1111, 32'h8000_0400, 32'h1111_1111, 32'h0, 1'b1, 3, "e_w_above");
    txn(0, 4'b1111, 32'h8000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0, 3, "w_top");
    txn(0, 4'b0000, 32'h8000_03FC, 32'h0, 32'hCAFE_F00D, 1'b0, 3, "r_top");
    txn(0, 4'b0000, 32'h8000_0000, 32'h0, 32'hA500_1234, 1'b0, 3, "r_w0_nowrap");
    txn(0, 4'b0001, 32'h8000_0001, 32'h0000_0077, 32'h0, 1'b0, 3, "w_byte1");
    txn(0, 4'b0011, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0, 3, "w_half2");
    txn(0, 4'b0000, 32'h8000_0000, 32'h0, 32'hBEEF_7734, 1'b0, 3, "r_w0_final");
    txn(0, 4'b0000, 32'h8000_0002, 32'h0, 32'h0000_BEEF, 1'b0, 3, "r_half2");

    // Response backpressure with a second request held during WAIT/RESP
    rsp_rdy[0] = 1'b0;
    vld[0]  = 1'b1;
    wen[0]  = 4'b0000;
    addr[0] = 32'h8000_0010;
    step();
    addr[0] = 32'h8000_03FC;
    k = 0;
    while (!rvld[0] && k < 50) begin
      step();
      k++;
    end
    chk("bp_lat", 32'(k + 1), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld",   {31'b0, rvld[0]}, 32'd1);
      chk("bp_rdata", rdata[0],          32'hDEAD_BEEF);
      chk("bp_err",   {31'b0, err[0]},  32'd0);
      chk("bp_rdy",   {31'b0, rdy[0]},  32'd0);
      step();
    end
    rsp_rdy[0] = 1'b1;
    step();
    chk("bp_post_vld", {31'b0, rvld[0]}, 32'd0);
    chk("bp_post_rdy", {31'b0, rdy[0]},  32'd1);
    step();
    vld[0] = 1'b0;
    k = 0;
    while (!rvld[0] && k < 50) begin
      step();
      k++;
    end
    chk("bp2_lat",   32'(k + 1), 32'd3);
    chk("bp2_rdata", rdata[0],   32'hCAFE_F00D);
    step();

    // Reset mid-operation, LATENCY=4
    txn(1, 4'b1111, 32'h8000_0020, 32'h1111_1111, 32'h0, 1'b0, 4, "l4_w");
    txn(1, 4'b0000, 32'h8000_0020, 32'h0, 32'h1111_1111, 1'b0, 4, "l4_r");
    vld[1]   = 1'b1;
    wen[1]   = 4'b1111;
    addr[1]  = 32'h8000_0020;
    wdata[1] = 32'h2222_2222;
    step();
    vld[1]   = 1'b0;
    rst_n[1] = 1'b0;
    step();
    chk("mr_rdy", {31'b0, rdy[1]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mr_vld",   {31'b0, rvld[1]}, 32'd0);
      chk("mr_rdata", rdata[1],          32'd0);
      step();
    end
    rst_n[1] = 1'b1;
    step();
    chk("mr_post_rdy", {31'b0, rdy[1]},  32'd1);
    chk("mr_post_vld", {31'b0, rvld[1]}, 32'd0);
    txn(1, 4'b0000, 32'h8000_0020, 32'h0, 32'h1111_1111, 1'b0, 4, "mr_old");

    // LATENCY=1 path
    txn(2, 4'b1111, 32'h8000_0020, 32'h55AA_55AA, 32'h0, 1'b0, 1, "l1_w");
    txn(2, 4'b0000, 32'h8000_0020, 32'h0, 32'h55AA_55AA, 1'b0, 1, "l1_r");
    txn(2, 4'b0000, 32'h8000_0021, 32'h0, 32'h0055_AA55, 1'b0, 1, "l1_r1");
    txn(2, 4'b0000, 32'h8000_0400, 32'h0, 32'h0, 1'b1, 1, "l1_e");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
